// File: rtl/burst_read_buffer.sv
// burst_read_buffer: fetches req_count bursts from memory into a first-word-fall-through FIFO.
// Define BURST_READ_BUFFER_CHECK_EN to build the sticky protocol checker driving err.
module burst_read_buffer #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_start,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_count,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_wait_n,
    input  logic                  mem_valid,
    input  logic                  mem_burstDone,
    output logic                  err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SPACE = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - BURST_LEN);
    localparam logic [BW-1:0] BLEN = BW'(BURST_LEN);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic [BW-1:0]         beat;
    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic                  push, pop, last_burst;

    // beat cap keeps a misbehaving memory from overrunning the space reserved in SPACE
    assign push       = state == DATA && mem_valid && beat != BLEN;
    assign pop        = out_valid && out_ready;
    assign last_burst = remaining == 16'd1;
    assign busy       = state != IDLE;
    assign mem_rd     = state == REQ;
    assign mem_addr   = addr;
    assign out_valid  = fifo_count != '0;
    assign out_data   = fifo_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat      <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req_start) begin
                    if (req_count != 16'd0) begin
                        addr      <= req_addr;
                        remaining <= req_count;
                        state     <= SPACE;
                    end else done <= 1'b1;
                end
                SPACE: if (fifo_count <= FILL_MAX) state <= REQ;
                REQ: if (mem_wait_n) begin
                    state <= DATA;
                    beat  <= '0;
                end
                DATA: begin
                    if (push) beat <= beat + BW'(1);
                    if (mem_burstDone) begin
                        addr      <= addr + STEP;
                        remaining <= remaining - 16'd1;
                        state     <= last_burst ? IDLE : SPACE;
                        done      <= last_burst;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= mem_dout;
    end

`ifdef BURST_READ_BUFFER_CHECK_EN
    logic          err_q;
    logic [BW-1:0] burst_words;
    assign burst_words = beat + BW'(mem_valid);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else if ((mem_valid && state != DATA) || (state == DATA && mem_burstDone && burst_words != BLEN)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_burst_read_buffer.sv
// tb_burst_read_buffer: table-driven and randomized transfers against a memory/consumer model.
module tb_burst_read_buffer;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int DEPTH = 16;
`ifdef BURST_READ_BUFFER_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clock = 1'b0, reset_n = 1'b0, req_start = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_count = '0;
    logic          busy, done, out_valid, mem_rd, err;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_wait_n = 1'b0, mem_valid = 1'b0, mem_burstDone = 1'b0;

    burst_read_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .req_start(req_start), .req_addr(req_addr),
        .req_count(req_count), .busy(busy), .done(done), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_wait_n(mem_wait_n), .mem_valid(mem_valid),
        .mem_burstDone(mem_burstDone), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   count;
        int            wait_hold;
        int            ready_pct;
        int            gap_pct;
        logic [AW-1:0] exp_last;
        int            exp_words;
    } vec_t;

    int compared = 0, mismatched = 0;
    logic [DW-1:0] exp_words[$];
    logic [AW-1:0] exp_addrs[$];
    int wait_hold = 0, wait_ctr = 0, words_left = 0, idx = 0, short_len = BL, gap_pct = 0, halt_at = -1;
    int accepts = 0, stall_cycles = 0, ready_pct = 100, pop_budget = 0, pops = 0, done_cnt = 0;
    int acc0 = 0, pop0 = 0, nbursts = 0;
    logic [AW-1:0] resp_addr = '0, held_addr = '0, last_addr = '0;
    bit pending = 0, just_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {7'd0, a} * 32'h9E3779B1;
        return x[31:16] ^ x[15:0];
    endfunction

    // memory responder and consumer, both acting on the falling edge
    always @(negedge clock) begin
        bit was_pending;
        mem_valid = 1'b0;
        mem_burstDone = 1'b0;
        if (done) done_cnt++;
        if (just_acc) begin
            check("mem_rd_low_in_data", {31'd0, mem_rd}, 0);
            just_acc = 0;
        end
        if (pending) begin
            check("stall_rd_stable", {31'd0, mem_rd}, 1);
            check("stall_addr_stable", {7'd0, mem_addr}, {7'd0, held_addr});
        end
        was_pending = pending;
        pending = 0;
        if (words_left > 0 && idx != halt_at && $urandom_range(1, 100) > gap_pct) begin
            mem_valid = 1'b1;
            mem_dout = memword(resp_addr + AW'(2 * idx));
            idx++;
            words_left--;
            mem_burstDone = words_left == 0;
        end
        mem_wait_n = 1'b0;
        if (mem_rd) begin
            if (!was_pending) wait_ctr = wait_hold;
            if (wait_ctr > 0) begin
                wait_ctr--;
                stall_cycles++;
                pending = 1;
                held_addr = mem_addr;
            end else begin
                mem_wait_n = 1'b1;
                accepts++;
                just_acc = 1;
                resp_addr = mem_addr;
                last_addr = mem_addr;
                words_left = short_len;
                idx = 0;
                if (exp_addrs.size() == 0) check("unexpected_req", {7'd0, mem_addr}, 32'hFFFFFFFF);
                else check("mem_addr", {7'd0, mem_addr}, {7'd0, exp_addrs.pop_front()});
            end
        end
        out_ready = pop_budget > 0 || $urandom_range(1, 100) <= ready_pct;
        if (out_valid && out_ready) begin
            pops++;
            if (pop_budget > 0) pop_budget--;
            if (exp_words.size() == 0) check("unexpected_word", {16'd0, out_data}, 32'hFFFFFFFF);
            else check("out_data", {16'd0, out_data}, {16'd0, exp_words.pop_front()});
        end
    end

    task automatic wait_neg;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req_start = 1'b0;
        wait_neg;
        words_left = 0;
        pending = 0;
        just_acc = 0;
        wait_ctr = 0;
        pop_budget = 0;
        exp_words.delete();
        exp_addrs.delete();
        wait_neg;
        reset_n = 1'b1;
        wait_neg;
    endtask

    // expected stream: bursts at start + 8k (mod 2^AW), words at consecutive 2-byte addresses
    task automatic start_xfer(input logic [AW-1:0] a, input logic [15:0] cnt, input int wpb);
        for (int k = 0; k < int'(cnt); k++) begin
            logic [AW-1:0] ba;
            ba = a + AW'(8 * k);
            exp_addrs.push_back(ba);
            for (int i = 0; i < wpb; i++) exp_words.push_back(memword(ba + AW'(2 * i)));
        end
        done_cnt = 0;
        acc0 = accepts;
        pop0 = pops;
        nbursts = int'(cnt);
        req_addr = a;
        req_count = cnt;
        req_start = 1'b1;
        wait_neg;
        req_start = 1'b0;
    endtask

    task automatic finish_xfer(input logic [AW-1:0] exp_last, input int nwords);
        int t;
        t = 0;
        while ((done_cnt == 0 || exp_words.size() != 0 || words_left != 0) && t < 3000) begin
            wait_neg;
            t++;
        end
        check("xfer_in_time", {31'd0, t < 3000}, 1);
        wait_neg;
        check("done_pulses", done_cnt, 1);
        check("busy_after", {31'd0, busy}, 0);
        check("last_mem_addr", {7'd0, last_addr}, {7'd0, exp_last});
        check("words_out", pops - pop0, nwords);
        check("bursts", accepts - acc0, nbursts);
    endtask

    initial begin
        vec_t vecs[6];
        int t;
        vecs[0] = '{25'h0001000, 16'd2, 0, 100, 0, 25'h0001008, 8};
        vecs[1] = '{25'h1FFFFF8, 16'd2, 1, 70, 20, 25'h0000000, 8};
        vecs[2] = '{25'h0123450, 16'd3, 2, 50, 30, 25'h0123460, 12};
        vecs[3] = '{25'h1FFFFF0, 16'd5, 0, 30, 10, 25'h0000010, 20};
        vecs[4] = '{25'h0000ABC, 16'd0, 0, 100, 0, 25'h1ABCDEF, 0};
        vecs[5] = '{25'h0000002, 16'd1, 3, 100, 50, 25'h0000002, 4};

        do_reset;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mem_rd", {31'd0, mem_rd}, 0);
        check("rst_mem_addr", {7'd0, mem_addr}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);

        foreach (vecs[v]) begin
            wait_hold = vecs[v].wait_hold;
            ready_pct = vecs[v].ready_pct;
            gap_pct = vecs[v].gap_pct;
            last_addr = 25'h1ABCDEF;
            start_xfer(vecs[v].addr, vecs[v].count, BL);
            finish_xfer(vecs[v].exp_last, vecs[v].exp_words);
        end

        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] a;
            logic [15:0] c;
            a = AW'($urandom);
            c = 16'($urandom_range(1, 4));
            wait_hold = $urandom_range(0, 2);
            ready_pct = $urandom_range(30, 100);
            gap_pct = $urandom_range(0, 40);
            start_xfer(a, c, BL);
            finish_xfer(a + AW'(8 * (int'(c) - 1)), 4 * int'(c));
        end

        // long wait_n stall
        wait_hold = 5;
        gap_pct = 0;
        ready_pct = 100;
        stall_cycles = 0;
        start_xfer(25'h0005000, 16'd1, BL);
        finish_xfer(25'h0005000, 4);
        check("stall_cycles", stall_cycles, 5);
        wait_hold = 0;

        // consumer stalled: four bursts fill the FIFO, fifth waits for space
        ready_pct = 0;
        start_xfer(25'h0002000, 16'd5, BL);
        for (int i = 0; i < 150; i++) wait_neg;
        check("park_bursts", accepts - acc0, 4);
        check("park_mem_rd", {31'd0, mem_rd}, 0);
        check("park_busy", {31'd0, busy}, 1);
        check("park_out_valid", {31'd0, out_valid}, 1);
        pop_budget = 4;
        t = 0;
        while (accepts - acc0 < 5 && t < 200) begin
            wait_neg;
            t++;
        end
        check("resume_bursts", accepts - acc0, 5);
        check("resume_pops", pops - pop0, 4);
        ready_pct = 100;
        finish_xfer(25'h0002020, 20);

        // reset mid-burst after two words
        ready_pct = 0;
        halt_at = 2;
        start_xfer(25'h0003000, 16'd1, BL);
        t = 0;
        while (idx != 2 && t < 100) begin
            wait_neg;
            t++;
        end
        wait_neg;
        check("mid_out_valid", {31'd0, out_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 0);
        check("async_busy", {31'd0, busy}, 0);
        check("async_mem_rd", {31'd0, mem_rd}, 0);
        exp_words.delete();
        exp_addrs.delete();
        wait_neg;
        ready_pct = 100;
        halt_at = -1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) wait_neg;
        check("drop_out_valid", {31'd0, out_valid}, 0);
        check("drop_busy", {31'd0, busy}, 0);
        check("drop_done", done_cnt, 0);
        check("stray_valid_err", {31'd0, err}, {31'd0, CHK});
        do_reset;
        check("err_cleared", {31'd0, err}, 0);

        // short burst: burstDone with the third word
        short_len = 3;
        start_xfer(25'h0004000, 16'd1, 3);
        finish_xfer(25'h0004000, 3);
        check("short_err", {31'd0, err}, {31'd0, CHK});
        for (int i = 0; i < 5; i++) wait_neg;
        check("short_err_sticky", {31'd0, err}, {31'd0, CHK});
        short_len = BL;
        do_reset;
        check("short_err_reset", {31'd0, err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/burst_read_buffer.md
BURST_READ_BUFFER -- requirements
Module: burst_read_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_WIDTH, 25, memory byte address width; DATA_WIDTH, 16, word width; BURST_LEN, 4, words per burst (power of two, >=2); DEPTH, 16, FIFO words (power of two, >=2*BURST_LEN).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_start  in  1  one-cycle pulse, start a transfer
- req_addr  in  ADDR_WIDTH  start byte address, sampled with req_start
- req_count  in  16  number of bursts, sampled with req_start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, last burst completed
- out_data  out  DATA_WIDTH  FIFO head word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pops head when out_valid & out_ready
- mem_rd  out  1  burst read request to memory arbiter client port
- mem_addr  out  ADDR_WIDTH  burst start address
- mem_dout  in  DATA_WIDTH  read data
- mem_wait_n  in  1  high = request accepted this cycle
- mem_valid  in  1  mem_dout holds a burst word
- mem_burstDone  in  1  final word of burst
- err  out  1  sticky protocol error flag (see Configuration)

Function
REQ-003 FSM SHALL have states IDLE, SPACE, REQ, DATA.
REQ-004 IDLE: on req_start with req_count!=0, latch address and count, go SPACE; with req_count==0, pulse done next cycle and stay IDLE.
REQ-005 req_start SHALL be ignored outside IDLE.
REQ-006 SPACE: go REQ when DEPTH - fifo_count >= BURST_LEN, else stay.
REQ-007 REQ: mem_rd=1 and mem_addr=current address; transition to DATA on the edge where mem_rd & mem_wait_n; mem_rd and mem_addr SHALL be stable while mem_wait_n=0.
REQ-008 mem_rd SHALL be 0 in every state other than REQ.
REQ-009 DATA: each cycle with mem_valid=1 SHALL push mem_dout into the FIFO; pushes in this state SHALL never exceed the space reserved in SPACE.
REQ-010 On mem_burstDone in DATA: address += BURST_LEN*DATA_WIDTH/8 modulo 2^ADDR_WIDTH, remaining count -= 1; if remaining becomes 0 go IDLE and pulse done in the same cycle the state returns to IDLE, else go SPACE.
REQ-011 mem_valid and mem_burstDone SHALL be ignored (no push) in IDLE, SPACE, REQ.
REQ-012 busy SHALL be 1 in SPACE, REQ and DATA, 0 in IDLE.
REQ-013 FIFO SHALL be first-word-fall-through; out_data valid in the same cycle out_valid rises; a word pushed at edge N is visible at out_data after edge N when FIFO was empty.
REQ-014 Simultaneous push and pop SHALL keep fifo_count unchanged, including at full and at one-entry.
REQ-015 Pop with out_valid=0 SHALL have no effect; FIFO pointers wrap modulo DEPTH.
REQ-016 FIFO contents SHALL persist across transfers; draining is independent of the FSM.

Reset
REQ-017 reset_n low SHALL asynchronously force: state IDLE, FIFO empty, out_valid 0, mem_rd 0, mem_addr 0, busy 0, done 0, err 0, counters 0.
REQ-018 Reset asserted mid-burst SHALL abandon the burst; words arriving after release are dropped per REQ-011.

Configuration
REQ-019 Macro BURST_READ_BUFFER_CHECK_EN defined: err SHALL set (sticky until reset) when mem_valid occurs outside DATA, or mem_burstDone arrives with a word count for that burst other than BURST_LEN.
REQ-020 Macro undefined: err SHALL be tied 0 and no checker logic SHALL be synthesised; function otherwise identical.

Verification
REQ-021 req_addr=0x1000, req_count=2, mem_wait_n=1, out_ready=1 -> mem_addr 0x1000 then 0x1008, 8 words out in order, one done pulse, busy 0 after.
REQ-022 mem_wait_n held 0 for 5 cycles in REQ -> mem_rd and mem_addr stable 5 cycles, DATA entered on first wait_n=1 edge.
REQ-023 out_ready=0, req_count=5, DEPTH=16 -> exactly 4 bursts fetched, FSM parked in SPACE, mem_rd 0; one pop of 4 words resumes burst 5.
REQ-024 req_addr=0x1FFFFF8, req_count=2 -> second mem_addr 0x0000000 (wrap).
REQ-025 reset_n pulsed low mid-DATA after 2 of 4 words -> out_valid 0, busy 0, mem_rd 0 immediately; trailing mem_valid words not pushed.
REQ-026 CHECK_EN defined, burst ends with mem_burstDone after 3 words -> err=1 and stays 1 until reset; undefined -> err=0.
